// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide engine and the ALU control.
//   - FSM state encodings for mult_div_unit
//   - StoreMD encodings: control uses these to pick which result to store
package md_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_DIV  = 2'b01;
    localparam logic [1:0] MD_MUL  = 2'b10;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the ALU control (master) and the
// multiply/divide engine (slave).
//   multOp/divOp  : one-cycle start pulses (master -> slave)
//   srcA/srcB     : signed operands, sampled on the start edge
//   busy/done     : engine status; done is a one-cycle pulse
//   hi/lo/divZero : results, held until the next done or reset
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             multOp;
    logic             divOp;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             divZero;

    modport master (
        output multOp, divOp, srcA, srcB,
        input  busy, done, hi, lo, divZero
    );

    modport slave (
        input  multOp, divOp, srcA, srcB,
        output busy, done, hi, lo, divZero
    );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration (combinational).
//   rem_i     : partial remainder (WIDTH+1 bits, always < divisor)
//   divisor_i : unsigned divisor magnitude
//   bit_i     : next dividend bit, MSB first
//   rem_o     : updated partial remainder
//   q_o       : quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {2'b00, divisor_i};
        // Non-negative trial: the divisor fits, keep the difference.
        q_o     = ~trial[WIDTH+1];
        rem_o   = q_o ? trial[WIDTH:0] : shifted[WIDTH:0];
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide engine.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-low
//   bus   : slave side of mult_div_unit_if (start pulses, operands, results)
// Operands are reduced to unsigned magnitudes on the start edge, iterated
// one bit per clock (shift-add multiply / restoring divide), and the signs
// are reapplied in the single FIN cycle that also pulses done.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_unit_if.slave bus
);
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   op_q, op_d;       // mult: |A| multiplicand; div: |B| divisor
    logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial product, multiplier}; div: low half = dividend/quotient
    logic [WIDTH:0]     rem_q, rem_d;
    logic               neg_q, neg_d;     // product / quotient negate
    logic               rneg_q, rneg_d;   // remainder takes dividend sign
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;
    logic               divzero_q, divzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     step_rem;
    logic               step_q;
    logic [2*WIDTH-1:0] prod_signed;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .divisor_i (op_q),
        .bit_i     (acc_q[WIDTH-1]),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
        abs_a       = bus.srcA[WIDTH-1] ? -bus.srcA : bus.srcA;
        abs_b       = bus.srcB[WIDTH-1] ? -bus.srcB : bus.srcB;
        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
        prod_signed = neg_q ? -acc_q : acc_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        divzero_d = divzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                neg_d  = bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1];
                rneg_d = bus.srcA[WIDTH-1];
                cnt_d  = '0;
                rem_d  = '0;
                if (bus.multOp) begin
                    state_d  = ST_MUL;
                    op_d     = abs_a;
                    acc_d    = {{WIDTH{1'b0}}, abs_b};
                    is_div_d = 1'b0;
                    dz_d     = 1'b0;
                end else if (bus.divOp) begin
                    dz_d     = (bus.srcB == '0);
                    state_d  = (bus.srcB == '0) ? ST_FIN : ST_DIV;
                    op_d     = abs_b;
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    is_div_d = 1'b1;
                end
            end
            ST_MUL: begin
                // Add multiplicand into the upper half, then shift right;
                // the carry lands in bit 2W-1 after the shift.
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIN;
            end
            ST_DIV: begin
                // Dividend bits leave the top, quotient bits enter the bottom.
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIN;
            end
            default: begin  // ST_FIN
                done_d    = 1'b1;
                divzero_d = dz_q;
                state_d   = ST_IDLE;
                if (!is_div_q) begin
                    hi_d = prod_signed[2*WIDTH-1:WIDTH];
                    lo_d = prod_signed[WIDTH-1:0];
                end else if (!dz_q) begin
                    lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.divZero = divzero_q;
endmodule
